hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core.
- Detects load-use hazards, data-memory wait states, EX-resolved control redirects and traps.
- Drives the stall/flush controls consumed by the IF and ID stage registers, plus the PC-source select.
- Keeps a perf counter of stall cycles and a sticky bus-timeout flag.

---
 rtl/hazard_ctrl_pkg.sv | 29 ++
 rtl/hazard_detect.sv | 25 ++
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | hazard_ctrl_pkg : shared types for the pipeline hazard sequencer |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    HZ_RUN        = 3'd0,
    HZ_LU_BUBBLE  = 3'd1,
    HZ_MEM_WAIT   = 3'd2,
    HZ_REDIRECT   = 3'd3,
    HZ_TRAP_DRAIN = 3'd4
  } hz_state_e;

  typedef enum logic [1:0] {
    PC_SEL_SEQ  = 2'd0,
    PC_SEL_EX   = 2'd1,
    PC_SEL_TRAP = 2'd2,
    PC_SEL_MEPC = 2'd3
  } pc_sel_e;

  // Minimum bit width able to hold values 0..v (never narrower than 1).
  function automatic int unsigned cnt_bits(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | hazard_detect : combinational load-use compare ID vs EX          |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module hazard_detect (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_uses_rs1,
  input  logic       i_uses_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_load,
  output logic       o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit  = i_uses_rs2 && (i_id_rs2 == i_ex_rd);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign o_load_use = i_ex_load && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | hazard_ctrl : stall/flush/PC-select sequencer for the 5-stage core|
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TRAP_DRAIN  = 2,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           id_rs1_add_i,
  input  logic [4:0]           id_rs2_add_i,
  input  logic                 id_uses_rs1_i,
  input  logic                 id_uses_rs2_i,
  input  logic [4:0]           ex_rd_add_i,
  input  logic                 ex_mem_rd_i,
  input  logic                 ex_redirect_i,
  input  logic                 ex_trap_i,
  input  logic                 ex_mret_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_rvalid_i,
  output logic                 stall_if_o,
  output logic                 stall_id_o,
  output logic                 flush_id_o,
  output logic                 flush_ex_o,
  output logic [1:0]           pc_sel_o,
  output logic [2:0]           state_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic                 bus_err_o
);

  localparam int unsigned c_tmo_w = cnt_bits(MEM_TIMEOUT);
  localparam int unsigned c_drn_w = cnt_bits(TRAP_DRAIN);
  localparam logic [c_tmo_w-1:0] c_tmo_last  = c_tmo_w'(MEM_TIMEOUT - 1);
  localparam logic [c_drn_w-1:0] c_drain_init = c_drn_w'((TRAP_DRAIN > 1) ? (TRAP_DRAIN - 1) : 0);

  hz_state_e            r_state;
  hz_state_e            w_next;
  logic [c_tmo_w-1:0]   r_tmo;
  logic [c_tmo_w-1:0]   w_tmo_nxt;
  logic [c_drn_w-1:0]   r_drain;
  logic [c_drn_w-1:0]   w_drain_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_bus_err;
  logic                 w_bus_err_set;
  logic                 w_load_use;
  logic                 w_trap_any;
  logic                 w_mem_wait;
  logic                 w_stall;
  logic                 w_flush_id;
  logic                 w_flush_ex;
  pc_sel_e              w_pc_sel;

  hazard_detect u_detect (
    .i_id_rs1   (id_rs1_add_i),
    .i_id_rs2   (id_rs2_add_i),
    .i_uses_rs1 (id_uses_rs1_i),
    .i_uses_rs2 (id_uses_rs2_i),
    .i_ex_rd    (ex_rd_add_i),
    .i_ex_load  (ex_mem_rd_i),
    .o_load_use (w_load_use)
  );

  assign w_trap_any = ex_trap_i || ex_mret_i;
  assign w_mem_wait = dmem_req_i && !dmem_rvalid_i;

  always_comb begin
    w_next        = r_state;
    w_tmo_nxt     = r_tmo;
    w_drain_nxt   = r_drain;
    w_bus_err_set = 1'b0;
    w_stall       = 1'b0;
    w_flush_id    = 1'b0;
    w_flush_ex    = 1'b0;
    w_pc_sel      = PC_SEL_SEQ;
    case (r_state)
      // The bubble cycle still sees traps, redirects and the load's own
      // memory access; only a repeated load-use stall is suppressed.
      HZ_RUN, HZ_LU_BUBBLE: begin
        w_next = HZ_RUN;
        if (w_trap_any) begin
          w_pc_sel    = ex_trap_i ? PC_SEL_TRAP : PC_SEL_MEPC;
          w_flush_id  = 1'b1;
          w_flush_ex  = 1'b1;
          w_drain_nxt = c_drain_init;
          w_next      = HZ_TRAP_DRAIN;
        end else if (ex_redirect_i) begin
          w_pc_sel   = PC_SEL_EX;
          w_flush_id = 1'b1;
          w_flush_ex = 1'b1;
          w_next     = HZ_REDIRECT;
        end else if (w_mem_wait) begin
          w_stall   = 1'b1;
          w_tmo_nxt = '0;
          w_next    = HZ_MEM_WAIT;
        end else if (w_load_use && (r_state == HZ_RUN)) begin
          w_stall = 1'b1;
          w_next  = HZ_LU_BUBBLE;
        end
      end
      HZ_MEM_WAIT: begin
        if (dmem_rvalid_i) begin
          w_next = HZ_RUN;
        end else begin
          w_stall = 1'b1;
          if (r_tmo == c_tmo_last) begin
            w_bus_err_set = 1'b1;
            w_next        = HZ_RUN;
          end else begin
            w_tmo_nxt = r_tmo + 1'b1;
          end
        end
      end
      HZ_REDIRECT: begin
        w_flush_id = 1'b1;
        w_next     = HZ_RUN;
        if (w_trap_any) begin
          w_pc_sel    = ex_trap_i ? PC_SEL_TRAP : PC_SEL_MEPC;
          w_flush_ex  = 1'b1;
          w_drain_nxt = c_drain_init;
          w_next      = HZ_TRAP_DRAIN;
        end
      end
      HZ_TRAP_DRAIN: begin
        w_flush_id = 1'b1;
        w_flush_ex = 1'b1;
        if (r_drain == '0) begin
          w_next = HZ_RUN;
        end else begin
          w_drain_nxt = r_drain - 1'b1;
        end
      end
      default: w_next = HZ_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= HZ_RUN;
      r_tmo     <= '0;
      r_drain   <= '0;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tmo   <= w_tmo_nxt;
      r_drain <= w_drain_nxt;
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_bus_err_set) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  // Outputs are forced quiet while reset is held, independent of inputs.
  assign stall_if_o  = !rst && w_stall;
  assign stall_id_o  = !rst && w_stall;
  assign flush_id_o  = !rst && w_flush_id;
  assign flush_ex_o  = !rst && w_flush_ex;
  assign pc_sel_o    = rst ? 2'd0 : w_pc_sel;
  assign state_o     = r_state;
  assign stall_cnt_o = r_cnt;
  assign bus_err_o   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_hazard_ctrl : self-checking bench for hazard_ctrl             |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int TRAP_DRAIN  = 2;
  localparam int CNT_WIDTH   = 4;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [4:0]           id_rs1_add_i = '0;
  logic [4:0]           id_rs2_add_i = '0;
  logic                 id_uses_rs1_i = 1'b0;
  logic                 id_uses_rs2_i = 1'b0;
  logic [4:0]           ex_rd_add_i = '0;
  logic                 ex_mem_rd_i = 1'b0;
  logic                 ex_redirect_i = 1'b0;
  logic                 ex_trap_i = 1'b0;
  logic                 ex_mret_i = 1'b0;
  logic                 dmem_req_i = 1'b0;
  logic                 dmem_rvalid_i = 1'b0;
  logic                 stall_if_o;
  logic                 stall_id_o;
  logic                 flush_id_o;
  logic                 flush_ex_o;
  logic [1:0]           pc_sel_o;
  logic [2:0]           state_o;
  logic [CNT_WIDTH-1:0] stall_cnt_o;
  logic                 bus_err_o;

  hazard_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TRAP_DRAIN  (TRAP_DRAIN),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1_add_i  (id_rs1_add_i),
    .id_rs2_add_i  (id_rs2_add_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .ex_rd_add_i   (ex_rd_add_i),
    .ex_mem_rd_i   (ex_mem_rd_i),
    .ex_redirect_i (ex_redirect_i),
    .ex_trap_i     (ex_trap_i),
    .ex_mret_i     (ex_mret_i),
    .dmem_req_i    (dmem_req_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .stall_if_o    (stall_if_o),
    .stall_id_o    (stall_id_o),
    .flush_id_o    (flush_id_o),
    .flush_ex_o    (flush_ex_o),
    .pc_sel_o      (pc_sel_o),
    .state_o       (state_o),
    .stall_cnt_o   (stall_cnt_o),
    .bus_err_o     (bus_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model context: what the pipeline is doing, as pending obligations.
  bit m_lu_done   = 1'b0;
  bit m_redir_tail = 1'b0;
  int m_wait_age  = -1;
  int m_drain_left = 0;
  int m_cnt       = 0;
  bit m_err       = 1'b0;

  bit e_stall, e_fid, e_fex, lu, n_lu, n_redir, n_err;
  int e_pc, e_state, n_wait, n_drain;

  always @(negedge clk) begin
    if (rst) begin
      m_lu_done = 0; m_redir_tail = 0; m_wait_age = -1; m_drain_left = 0; m_cnt = 0; m_err = 0;
      check("rst_stall_if", stall_if_o, 0);
      check("rst_flush_id", flush_id_o, 0);
      check("rst_flush_ex", flush_ex_o, 0);
      check("rst_pc_sel", pc_sel_o, 0);
      check("rst_state", state_o, 0);
      check("rst_cnt", stall_cnt_o, 0);
      check("rst_bus_err", bus_err_o, 0);
    end else begin
      lu = ex_mem_rd_i && (ex_rd_add_i != 0) &&
           ((id_uses_rs1_i && id_rs1_add_i == ex_rd_add_i) ||
            (id_uses_rs2_i && id_rs2_add_i == ex_rd_add_i));
      e_state = (m_drain_left > 0) ? 4 : (m_wait_age >= 0) ? 2 :
                m_redir_tail ? 3 : m_lu_done ? 1 : 0;
      e_stall = 0; e_fid = 0; e_fex = 0; e_pc = 0;
      n_lu = 0; n_redir = 0; n_wait = m_wait_age; n_drain = m_drain_left; n_err = m_err;
      if (m_drain_left > 0) begin
        e_fid = 1; e_fex = 1; n_drain = m_drain_left - 1;
      end else if (m_wait_age >= 0) begin
        if (dmem_rvalid_i) n_wait = -1;
        else begin
          e_stall = 1;
          n_wait = m_wait_age + 1;
          if (n_wait == MEM_TIMEOUT) begin n_wait = -1; n_err = 1; end
        end
      end else if (ex_trap_i || ex_mret_i) begin
        e_pc = ex_trap_i ? 2 : 3; e_fid = 1; e_fex = 1; n_drain = TRAP_DRAIN;
      end else if (m_redir_tail) begin
        e_fid = 1;
      end else if (ex_redirect_i) begin
        e_pc = 1; e_fid = 1; e_fex = 1; n_redir = 1;
      end else if (dmem_req_i && !dmem_rvalid_i) begin
        e_stall = 1; n_wait = 0;
      end else if (lu && !m_lu_done) begin
        e_stall = 1; n_lu = 1;
      end
      check("state", state_o, e_state);
      check("stall_if", stall_if_o, e_stall);
      check("stall_id", stall_id_o, e_stall);
      check("flush_id", flush_id_o, e_fid);
      check("flush_ex", flush_ex_o, e_fex);
      check("pc_sel", pc_sel_o, e_pc);
      check("stall_cnt", stall_cnt_o, m_cnt);
      check("bus_err", bus_err_o, m_err);
      m_lu_done = n_lu; m_redir_tail = n_redir; m_wait_age = n_wait;
      m_drain_left = n_drain; m_err = n_err;
      if (e_stall && m_cnt < CNT_MAX) m_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_add_i = '0; id_rs2_add_i = '0; id_uses_rs1_i = 0; id_uses_rs2_i = 0;
    ex_rd_add_i = '0; ex_mem_rd_i = 0; ex_redirect_i = 0; ex_trap_i = 0; ex_mret_i = 0;
    dmem_req_i = 0; dmem_rvalid_i = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(1); rst = 0;
  endtask

  task automatic mem_wait_then_valid(input int waits);
    dmem_req_i = 1; step(1);
    dmem_req_i = 0; step(waits);
    dmem_rvalid_i = 1; step(1);
    dmem_rvalid_i = 0;
  endtask

  initial begin
    idle();
    step(2);
    rst = 0;

    // Load-use on rs2, held two cycles: only the first cycle stalls.
    ex_mem_rd_i = 1; ex_rd_add_i = 5; id_rs2_add_i = 5; id_uses_rs2_i = 1;
    step(1);
    check("lu_state_bubble", state_o, 1);
    step(1); idle();
    check("lu_state_back", state_o, 0);
    check("lu_cnt", stall_cnt_o, 1);

    // Load to x0 never stalls.
    do_reset();
    ex_mem_rd_i = 1; ex_rd_add_i = 0; id_rs1_add_i = 0; id_uses_rs1_i = 1;
    step(2); idle();
    check("x0_cnt", stall_cnt_o, 0);
    check("x0_state", state_o, 0);

    // Memory wait: three stalled cycles, released on rvalid.
    dmem_req_i = 1; step(3);
    dmem_rvalid_i = 1; step(1); idle();
    check("mw_cnt", stall_cnt_o, 3);
    check("mw_state", state_o, 0);
    dmem_req_i = 1; dmem_rvalid_i = 1; step(1); idle();
    check("req_rvalid_same_cycle", state_o, 0);

    // Redirect, then trap+redirect, trap during drain, mret, trap in REDIRECT.
    ex_redirect_i = 1; step(1); idle();
    check("redir_state", state_o, 3);
    step(1);
    ex_trap_i = 1; ex_redirect_i = 1; step(1);
    idle(); ex_trap_i = 1;
    check("trap_state", state_o, 4);
    step(1); idle();
    check("drain_state", state_o, 4);
    step(1);
    check("drain_done", state_o, 0);
    ex_mret_i = 1; step(1); idle(); step(2);
    ex_redirect_i = 1; step(1); idle(); ex_trap_i = 1; step(1); idle();
    check("redir_trap_state", state_o, 4);
    step(3);

    // Timeout: rvalid never arrives.
    dmem_req_i = 1; step(1); dmem_req_i = 0;
    step(MEM_TIMEOUT);
    check("tmo_bus_err", bus_err_o, 1);
    check("tmo_state", state_o, 0);
    check("tmo_cnt", stall_cnt_o, 8);
    step(2);
    check("tmo_sticky", bus_err_o, 1);

    // Counter saturation at all-ones.
    mem_wait_then_valid(3);
    mem_wait_then_valid(3);
    check("cnt_sat", stall_cnt_o, CNT_MAX);
    ex_mem_rd_i = 1; ex_rd_add_i = 7; id_rs1_add_i = 7; id_uses_rs1_i = 1;
    step(1); idle(); step(1);
    check("cnt_sat_hold", stall_cnt_o, CNT_MAX);

    // Asynchronous reset in the middle of a memory wait.
    dmem_req_i = 1; step(2);
    check("pre_rst_state", state_o, 2);
    #2 rst = 1;
    #1;
    check("arst_state", state_o, 0);
    check("arst_stall", stall_if_o, 0);
    check("arst_cnt", stall_cnt_o, 0);
    check("arst_bus_err", bus_err_o, 0);
    idle();
    step(1); rst = 0;
    step(2);
    check("post_rst_state", state_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
